// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler.
// TICK_SCHED_ONESHOT_EN enables one-shot mode, the DONE state and done output.
package tick_sched_pkg;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_RUN,
        CH_DONE
    } ch_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: shadow/active config, divide counter and run state.
// TICK_SCHED_ONESHOT_EN adds one-shot mode and the sticky done flag.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [CNT_W-1:0] period,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    ch_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] sh_period;
    logic [CNT_W-1:0] act_period;
    logic [CNT_W-1:0] ld_period;

    // A write hitting the same cycle as start goes straight to active.
    assign ld_period = we ? period : sh_period;

`ifdef TICK_SCHED_ONESHOT_EN
    logic sh_mode;
    logic act_mode;
    logic ld_mode;
    logic done_q;

    assign ld_mode = we ? mode : sh_mode;
    assign done    = done_q;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign done        = 1'b0;
`endif

    assign busy = (state == CH_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CH_IDLE;
            cnt        <= '0;
            sh_period  <= '0;
            act_period <= '0;
            tick       <= 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
            sh_mode    <= MODE_PERIODIC;
            act_mode   <= MODE_PERIODIC;
            done_q     <= 1'b0;
`endif
        end else begin
            if (we) begin
                sh_period <= period;
`ifdef TICK_SCHED_ONESHOT_EN
                sh_mode   <= mode;
`endif
            end
            if (stop) begin
                state <= CH_IDLE;
                cnt   <= '0;
                tick  <= 1'b0;
`ifdef TICK_SCHED_ONESHOT_EN
                done_q <= 1'b0;
`endif
            end else if (start) begin
                state      <= CH_RUN;
                cnt        <= '0;
                tick       <= 1'b0;
                act_period <= ld_period;
`ifdef TICK_SCHED_ONESHOT_EN
                act_mode   <= ld_mode;
                done_q     <= 1'b0;
`endif
            end else if (state == CH_RUN) begin
                if (cnt == act_period) begin
                    tick <= 1'b1;
                    cnt  <= '0;
`ifdef TICK_SCHED_ONESHOT_EN
                    if (act_mode == MODE_ONESHOT) begin
                        state  <= CH_DONE;
                        done_q <= 1'b1;
                    end else begin
                        act_period <= sh_period;
                        act_mode   <= sh_mode;
                    end
`else
                    act_period <= sh_period;
`endif
                end else begin
                    cnt  <= cnt + CNT_W'(1);
                    tick <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick generator: config decode plus NUM_CH tick channels.
// TICK_SCHED_ONESHOT_EN enables one-shot channels and the done outputs.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]          cfg_period,
    input  logic                      cfg_mode,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         stop,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done
);

    localparam int CH_W = $clog2(NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we_i;

        // Out-of-range indices match no channel and are dropped.
        assign we_i = cfg_we && (cfg_ch == CH_W'(i));

        tick_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .we     (we_i),
            .period (cfg_period),
            .mode   (cfg_mode),
            .start  (start[i]),
            .stop   (stop[i]),
            .tick   (tick[i]),
            .busy   (busy[i]),
            .done   (done[i])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed timing pins plus random traffic
// checked every cycle against an interval-countdown reference model.
module tb_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 26;
`ifdef TICK_SCHED_ONESHOT_EN
    localparam bit OS = 1'b1;
`else
    localparam bit OS = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic              cfg_mode;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] stop;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    int n_pass;
    int n_total;

    tick_scheduler #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: per channel, cycles left until the next tick.
    int  m_sh[NUM_CH];
    int  m_act[NUM_CH];
    bit  m_msh[NUM_CH];
    bit  m_mact[NUM_CH];
    int  m_rem[NUM_CH];
    bit  m_run[NUM_CH];
    bit  m_dn[NUM_CH];
    bit  m_tk[NUM_CH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_sh[i] = 0; m_act[i] = 0; m_msh[i] = 0; m_mact[i] = 0;
                m_rem[i] = 0; m_run[i] = 0; m_dn[i] = 0; m_tk[i] = 0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                bit wr;
                wr = cfg_we && (int'(cfg_ch) == i);
                if (stop[i]) begin
                    m_run[i] = 0; m_tk[i] = 0; m_dn[i] = 0;
                end else if (start[i]) begin
                    m_act[i]  = wr ? int'(cfg_period) : m_sh[i];
                    m_mact[i] = wr ? cfg_mode : m_msh[i];
                    m_rem[i]  = m_act[i];
                    m_run[i]  = 1; m_tk[i] = 0; m_dn[i] = 0;
                end else if (m_run[i]) begin
                    if (m_rem[i] == 0) begin
                        m_tk[i] = 1;
                        if (OS && m_mact[i]) begin
                            m_run[i] = 0; m_dn[i] = 1;
                        end else begin
                            m_act[i]  = m_sh[i];
                            m_mact[i] = m_msh[i];
                            m_rem[i]  = m_act[i];
                        end
                    end else begin
                        m_rem[i]--; m_tk[i] = 0;
                    end
                end else begin
                    m_tk[i] = 0;
                end
                if (wr) begin
                    m_sh[i]  = int'(cfg_period);
                    m_msh[i] = cfg_mode;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [NUM_CH-1:0] et, eb, ed;
            for (int i = 0; i < NUM_CH; i++) begin
                et[i] = m_tk[i]; eb[i] = m_run[i]; ed[i] = m_dn[i];
            end
            chk("model_tick", tick, et);
            chk("model_busy", busy, eb);
            chk("model_done", done, ed);
        end
    end

    task automatic cfg(input int ch, input int p, input bit m);
        cfg_we = 1; cfg_ch = 2'(ch); cfg_period = CNT_W'(p); cfg_mode = m;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] t);
        start = s; stop = t;
        @(negedge clk);
        start = '0; stop = '0;
    endtask

    // Negedges until tick[ch] is seen high; -1 when the bound expires.
    task automatic measure(input int ch, input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick[ch] && n < lim);
        if (!tick[ch]) n = -1;
    endtask

    int n;
    int cnt_t;

    initial begin
        clk = 0; rst = 1; cfg_we = 0; cfg_ch = 0; cfg_period = 0;
        cfg_mode = 0; start = 0; stop = 0; n_pass = 0; n_total = 0;
        repeat (3) @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // ch0 periodic P=3
        cfg(0, 3, 0);
        pulse(4'b0001, 4'b0000);
        chk("ch0_busy", busy[0], 1);
        measure(0, 20, n); chk("ch0_first_lat", n, 4);
        measure(0, 20, n); chk("ch0_interval", n, 4);
        measure(0, 20, n); chk("ch0_interval2", n, 4);

        // ch1 P=9, one-shot when built in
        cfg(1, 9, 1);
        pulse(4'b0010, 4'b0000);
        measure(1, 30, n); chk("ch1_lat", n, 10);
`ifdef TICK_SCHED_ONESHOT_EN
        chk("ch1_done_set", done[1], 1);
        @(negedge clk);
        chk("ch1_busy_after", busy[1], 0);
        cnt_t = 0;
        repeat (20) begin
            @(negedge clk);
            cnt_t += int'(tick[1]);
        end
        chk("ch1_no_more_ticks", cnt_t, 0);
        chk("ch1_done_sticky", done[1], 1);
        pulse(4'b0010, 4'b0000);
        chk("ch1_done_clear", done[1], 0);
        chk("ch1_rerun_busy", busy[1], 1);
`else
        chk("ch1_done_tied", done[1], 0);
        measure(1, 30, n); chk("ch1_periodic", n, 10);
`endif
        pulse(4'b0000, 4'b0010);

        // ch2 reprogrammed mid-interval: 5 then 2
        cfg(2, 4, 0);
        pulse(4'b0100, 4'b0000);
        cfg(2, 1, 0);
        measure(2, 20, n); chk("ch2_old_rate", n + 1, 5);
        measure(2, 20, n); chk("ch2_new_rate", n, 2);
        measure(2, 20, n); chk("ch2_new_rate2", n, 2);

        // ch3 start+stop together, then restart at the wrap edge
        cfg(3, 5, 0);
        pulse(4'b1000, 4'b0000);
        repeat (2) @(negedge clk);
        pulse(4'b1000, 4'b1000);
        chk("ch3_stop_wins_tick", tick[3], 0);
        chk("ch3_stop_wins_busy", busy[3], 0);
        cfg(3, 2, 0);
        pulse(4'b1000, 4'b0000);
        measure(3, 20, n); chk("ch3_lat", n, 3);
        repeat (2) @(negedge clk);
        pulse(4'b1000, 4'b0000);
        chk("ch3_no_tick_on_restart", tick[3], 0);
        measure(3, 20, n); chk("ch3_after_restart", n, 3);

        // ch0 P=0: tick continuously high
        pulse(4'b0000, 4'b1111);
        cfg(0, 0, 0);
        pulse(4'b0001, 4'b0000);
        cnt_t = 0;
        repeat (8) begin
            @(negedge clk);
            cnt_t += int'(tick[0]);
        end
        chk("ch0_p0_cont", cnt_t, 8);

        // asynchronous reset while everything runs
        cfg(0, 2, 0); cfg(1, 3, 0); cfg(2, 4, 0); cfg(3, 5, 0);
        pulse(4'b1111, 4'b0000);
        repeat (7) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_tick", tick, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst = 0;
        cnt_t = 0;
        repeat (20) begin
            @(negedge clk);
            cnt_t += $countones(tick) + $countones(busy);
        end
        chk("arst_quiet", cnt_t, 0);

        // random traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            cfg_we     = ($urandom % 4 == 0);
            cfg_ch     = 2'($urandom % 4);
            cfg_period = CNT_W'($urandom % 8);
            cfg_mode   = 1'($urandom % 2);
            for (int i = 0; i < NUM_CH; i++) begin
                start[i] = ($urandom % 12 == 0);
                stop[i]  = ($urandom % 40 == 0);
            end
            @(negedge clk);
        end
        cfg_we = 0; start = 0; stop = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel programmable tick generator and timer controller. It shares one configurable divide engine per channel between the game logic requesters (VGA refresh pacing, animation steps, input debounce, timeouts). Each channel emits single-cycle `tick` enables at a programmed rate instead of deriving new clocks. The block runs on the system clock, and all consumers stay in that single clock domain.

## Interface
- `NUM_CH`, default 4: number of channels; legal range 2..8.
- `CNT_W`, default 26: counter/period width in bits; covers 1 s at 50 MHz.
- `clk` in 1: system clock (50 MHz); all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: write strobe for the shadow config of channel `cfg_ch`.
- `cfg_ch` in `$clog2(NUM_CH)`: channel index for the config write; index >= NUM_CH is ignored.
- `cfg_period` in `CNT_W`: divide value; tick interval is `cfg_period+1` cycles.
- `cfg_mode` in 1: 0 = periodic, 1 = one-shot.
- `start` in `NUM_CH`: per-channel start/restart pulse.
- `stop` in `NUM_CH`: per-channel stop pulse.
- `tick` out `NUM_CH`: registered one-cycle enable pulse per channel.
- `busy` out `NUM_CH`: the channel is in RUN.
- `done` out `NUM_CH`: sticky one-shot completion flag.

## Operation
- Per channel: shadow regs `sh_period`/`sh_mode`, active regs `act_period`/`act_mode`, a counter `cnt` of `CNT_W` bits, and a state machine `CH_IDLE`, `CH_RUN`, `CH_DONE`.
- Reset: all states go to IDLE; `cnt`, `sh_period`, and `act_period` clear to 0; modes clear to periodic; `tick`, `busy`, and `done` are all 0.
- Config write: `cfg_we` updates the shadow regs only. When `cfg_we` and `start` hit the same channel in the same cycle, the active regs take the new value (write-through).
- IDLE/DONE + `start`:
  - Go to RUN.
  - Clear `cnt` to 0.
  - Load active from shadow.
  - Clear `done`.
- RUN, each edge:
  - If `cnt == act_period`, then `tick` <= 1 and `cnt` <= 0.
  - In periodic mode, reload active from shadow.
  - In one-shot mode, go to DONE and set `done` <= 1.
  - Otherwise `cnt` increments and `tick` <= 0.
- RUN + `start`: the channel restarts (`cnt` <= 0, reload active). No tick is issued that cycle, even if a wrap was due.
- Any state + `stop`:
  - Go to IDLE.
  - Clear `cnt` to 0.
  - Set `tick` <= 0 and `done` <= 0.
- `stop` and `start` together: `stop` wins.
- A running channel reprogrammed through shadow switches rate only at its next wrap; the current interval completes at the old rate.
- DONE holds until `start` or `stop`. `busy` is 0 in DONE.
- Counter arithmetic is unsigned `CNT_W`-bit. `cnt` never exceeds `act_period`, so no overflow path exists.
- Channels are fully independent; there is no cross-channel priority.

## Timing
- Start sampled at edge k gives the first `tick` high during the cycle after edge k+1+P, where P = `act_period`. The latency is P+1 cycles.
- Subsequent periodic ticks occur every P+1 cycles.
- P = 0, periodic: `tick` stays high every cycle while in RUN.
- `busy` rises the cycle after the start edge and falls the cycle after the stop edge or the one-shot terminal edge.
- `done` rises on the same edge as the final one-shot `tick`.
- `rst` asserted mid-operation clears every output immediately and asynchronously. No tick is emitted after release until a new `start`.

## Configuration
- `TICK_SCHED_ONESHOT_EN` defined: one-shot mode, the DONE state, and the `done` output are all implemented as above.
- Not defined:
  - `cfg_mode` is ignored and all channels are periodic.
  - The DONE state is not built.
  - `done` is tied to 0.
  - Ports stay unchanged.

## Structure
- Package `tick_sched_pkg` holds:
  - `typedef enum logic [1:0] ch_state_t {CH_IDLE, CH_RUN, CH_DONE}`.
  - Mode constants `MODE_PERIODIC = 1'b0` and `MODE_ONESHOT = 1'b1`.
- Sub-module `tick_channel` contains one channel's shadow/active regs, counter, and state machine.
- `tick_scheduler` performs `cfg_ch` decode and generates `NUM_CH` instances of `tick_channel`.

## Test plan
- Reset, then program ch0 with P=3 periodic and start it → first tick 4 cycles after start, then every 4 cycles; `busy[0]` = 1.
- ch1 with P=9 one-shot (macro on) → exactly one tick 10 cycles after start, `done[1]` = 1 on the same edge, `busy[1]` = 0 afterwards, no further ticks; a new `start` clears `done`.
- ch2 running at P=4 gets a shadow write of P=1 mid-interval → the current interval stays 5 cycles, then intervals are 2 cycles.
- `start` and `stop` asserted together on ch3 while running → IDLE, `tick` = 0, `busy` = 0. A `start` at the exact wrap cycle → no tick, and the next tick arrives P+1 cycles later.
- ch0 at P=0 periodic → `tick[0]` is continuously high.
- `rst` pulsed while all channels run → all outputs are 0 asynchronously, and no ticks appear after release until a new `start`.
